// File: rtl/dmem_bytelane_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : dmem_bytelane_ctrl
// Brief    : Byte-lane data memory with extending loads, req/ack handshake and
//            WAIT_CYCLES wait states. Optional macro DMEM_MISALIGN_EXC_EN turns
//            misaligned/reserved accesses into err responses.
// Revision : 1.0 - initial release
// =============================================================================
module dmem_bytelane_ctrl #(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        busy,
  output logic        err
);

  localparam int         c_depth     = 1 << DEPTH_LOG2;
  localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic                  r_sext;
  logic [1:0]            r_size;
  logic [1:0]            r_lo;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_din;
  logic [31:0]           r_dout;
  logic                  r_ack;
  logic                  r_busy;
  logic [31:0]           r_mem [0:c_depth-1];

  logic                  w_idle;
  logic                  w_sel_we;
  logic                  w_sel_sext;
  logic [1:0]            w_sel_size;
  logic [1:0]            w_sel_lo;
  logic [DEPTH_LOG2-1:0] w_sel_idx;
  logic [31:0]           w_sel_din;
  logic [1:0]            w_size;
  logic [1:0]            w_lo;
  logic                  w_mis;
  logic                  w_commit;
  logic [3:0]            w_mask;
  logic [31:0]           w_wdata;
  logic [31:0]           w_word;
  logic [31:0]           w_shifted;
  logic [31:0]           w_load;
  logic                  w_unused_ok;

  // With zero wait states the commit edge is the acceptance edge, so the
  // live inputs are used in IDLE and the captured copy afterwards.
  assign w_idle      = (r_state == S_IDLE);
  assign w_sel_we    = w_idle ? we   : r_we;
  assign w_sel_sext  = w_idle ? sext : r_sext;
  assign w_sel_size  = w_idle ? size : r_size;
  assign w_sel_lo    = w_idle ? addr[1:0] : r_lo;
  assign w_sel_idx   = w_idle ? addr[DEPTH_LOG2+1:2] : r_idx;
  assign w_sel_din   = w_idle ? din  : r_din;
  assign w_unused_ok = ^{1'b0, addr[31:DEPTH_LOG2+2]};

  assign w_commit = rstn && ((w_idle && req && (WAIT_CYCLES == 0)) ||
                             ((r_state == S_WAIT) && (r_cnt == 4'd0)));

  always_comb begin
    w_mis  = 1'b0;
    w_lo   = w_sel_lo;
    w_size = w_sel_size;
`ifdef DMEM_MISALIGN_EXC_EN
    case (w_sel_size)
      2'b01:   w_mis = w_sel_lo[0];
      2'b10:   w_mis = |w_sel_lo;
      2'b11:   w_mis = 1'b1;
      default: w_mis = 1'b0;
    endcase
`else
    case (w_sel_size)
      2'b01:   w_lo = {w_sel_lo[1], 1'b0};
      2'b10,
      2'b11: begin
        w_lo   = 2'b00;
        w_size = 2'b10;
      end
      default: w_lo = w_sel_lo;
    endcase
`endif
  end

  always_comb begin
    w_mask  = 4'b1111;
    w_wdata = w_sel_din;
    case (w_size)
      2'b00: begin
        w_mask  = 4'b0001 << w_lo;
        w_wdata = {4{w_sel_din[7:0]}};
      end
      2'b01: begin
        w_mask  = w_lo[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_sel_din[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_word    = r_mem[w_sel_idx];
  assign w_shifted = w_word >> {w_lo, 3'b000};

  always_comb begin
    case (w_size)
      2'b00:   w_load = w_sel_sext ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                   : {24'd0, w_shifted[7:0]};
      2'b01:   w_load = w_sel_sext ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                   : {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_sel_we && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mask[i]) r_mem[w_sel_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_lo    <= 2'b00;
      r_idx   <= '0;
      r_din   <= 32'd0;
      r_dout  <= 32'd0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we   <= we;
            r_sext <= sext;
            r_size <= size;
            r_lo   <= addr[1:0];
            r_idx  <= addr[DEPTH_LOG2+1:2];
            r_din  <= din;
            r_busy <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_wait_init;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_commit) begin
        r_ack <= 1'b1;
        if (w_mis)          r_dout <= 32'd0;
        else if (!w_sel_we) r_dout <= w_load;
      end
    end
  end

`ifdef DMEM_MISALIGN_EXC_EN
  logic r_err;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         r_err <= 1'b0;
    else if (w_commit) r_err <= w_mis;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign dout = r_dout;
  assign ack  = r_ack;
  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bytelane_ctrl.sv
`default_nettype none
// Bench for dmem_bytelane_ctrl: one instance with no wait states, one with three.
module tb_dmem_bytelane_ctrl;

  logic        clk;
  logic        rstn;
  logic        req0, req3;
  logic        we, sext;
  logic [1:0]  size;
  logic [31:0] addr, din;
  logic [31:0] dout0, dout3;
  logic        ack0, ack3, busy0, busy3, err0, err3;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] edout;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[23];

  dmem_bytelane_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .INIT_FILE("")) u0 (
    .clk(clk), .rstn(rstn), .req(req0), .we(we), .size(size), .sext(sext),
    .addr(addr), .din(din), .dout(dout0), .ack(ack0), .busy(busy0), .err(err0)
  );

  dmem_bytelane_ctrl #(.DEPTH_LOG2(10), .WAIT_CYCLES(3), .INIT_FILE("")) u3 (
    .clk(clk), .rstn(rstn), .req(req3), .we(we), .size(size), .sext(sext),
    .addr(addr), .din(din), .dout(dout3), .ack(ack3), .busy(busy3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic w, logic [1:0] sz, logic sx, logic [31:0] a,
                              logic [31:0] d, logic [31:0] e, logic ee);
    vec_t v;
    v.w = w; v.sz = sz; v.sx = sx; v.a = a; v.d = d; v.edout = e; v.eerr = ee;
    return v;
  endfunction

  task automatic do_access(input bit use3, input vec_t v, input string nm);
    exp_t e;
    int   lat;
    @(negedge clk);
    we = v.w; size = v.sz; sext = v.sx; addr = v.a; din = v.d;
    if (use3) req3 = 1'b1; else req0 = 1'b1;
    e.dout = v.edout; e.err = v.eerr; e.lat = use3 ? 4 : 1;
    sbq.push_back(e);
    @(negedge clk);
    req0 = 1'b0; req3 = 1'b0;
    lat = 1;
    while (!(use3 ? ack3 : ack0) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    check({nm, "_latency"}, 32'(lat), 32'(e.lat));
    check({nm, "_dout"}, use3 ? dout3 : dout0, e.dout);
    check({nm, "_err"}, {31'd0, use3 ? err3 : err0}, {31'd0, e.err});
    @(negedge clk);
    check({nm, "_ack_pulse"}, {31'd0, use3 ? ack3 : ack0}, 32'd0);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; req0 = 1'b0; req3 = 1'b0;
    we = 1'b0; sext = 1'b0; size = 2'b00; addr = 32'd0; din = 32'd0;

    tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00F0, 32'h0,         1'b0);
    tbl[1]  = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'h8000_00F0, 1'b0);
    tbl[2]  = mk(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 32'h8000_00F0, 1'b0);
    tbl[3]  = mk(1'b1, 2'd0, 1'b0, 32'h13, 32'hFFFF_FFAB, 32'h8000_00F0, 1'b0);
    tbl[4]  = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hAB22_3344, 1'b0);
    tbl[5]  = mk(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,         32'hFFFF_FFAB, 1'b0);
    tbl[6]  = mk(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,         32'h0000_00AB, 1'b0);
    tbl[7]  = mk(1'b0, 2'd0, 1'b1, 32'h10, 32'h0,         32'h0000_0044, 1'b0);
    tbl[8]  = mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h0123_4567, 32'h0000_0044, 1'b0);
    tbl[9]  = mk(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_BEEF, 32'h0000_0044, 1'b0);
    tbl[10] = mk(1'b0, 2'd1, 1'b1, 32'h22, 32'h0,         32'hFFFF_BEEF, 1'b0);
    tbl[11] = mk(1'b0, 2'd1, 1'b0, 32'h22, 32'h0,         32'h0000_BEEF, 1'b0);
    tbl[12] = mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'hBEEF_4567, 1'b0);
    tbl[13] = mk(1'b0, 2'd1, 1'b1, 32'h20, 32'h0,         32'h0000_4567, 1'b0);
`ifdef DMEM_MISALIGN_EXC_EN
    tbl[14] = mk(1'b0, 2'd1, 1'b1, 32'h11, 32'h0,         32'h0,         1'b1);
    tbl[15] = mk(1'b0, 2'd2, 1'b0, 32'h12, 32'h0,         32'h0,         1'b1);
    tbl[16] = mk(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, 32'h0,         1'b1);
    tbl[17] = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hAB22_3344, 1'b0);
    tbl[18] = mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,         32'h0,         1'b1);
    tbl[19] = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hAB22_3344, 1'b0);
    tbl[20] = mk(1'b1, 2'd0, 1'b0, 32'h21, 32'h80,        32'hAB22_3344, 1'b0);
`else
    tbl[14] = mk(1'b0, 2'd1, 1'b1, 32'h11, 32'h0,         32'h0000_3344, 1'b0);
    tbl[15] = mk(1'b0, 2'd2, 1'b0, 32'h12, 32'h0,         32'hAB22_3344, 1'b0);
    tbl[16] = mk(1'b1, 2'd2, 1'b0, 32'h12, 32'hCAFE_F00D, 32'hAB22_3344, 1'b0);
    tbl[17] = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 1'b0);
    tbl[18] = mk(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 1'b0);
    tbl[19] = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 1'b0);
    tbl[20] = mk(1'b1, 2'd0, 1'b0, 32'h21, 32'h80,        32'hCAFE_F00D, 1'b0);
`endif
    tbl[21] = mk(1'b0, 2'd0, 1'b1, 32'h21, 32'h0,         32'hFFFF_FF80, 1'b0);
    tbl[22] = mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'hBEEF_8067, 1'b0);

    repeat (3) @(negedge clk);
    check("reset_u0_dout", dout0, 32'd0);
    check("reset_u0_flags", {29'd0, ack0, busy0, err0}, 32'd0);
    check("reset_u3_dout", dout3, 32'd0);
    check("reset_u3_flags", {29'd0, ack3, busy3, err3}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 23; i++) do_access(1'b0, tbl[i], $sformatf("row%0d", i));

    do_access(1'b1, mk(1'b1, 2'd2, 1'b0, 32'h40, 32'h1111_2222, 32'h0, 1'b0), "w3_sw40");
    do_access(1'b1, mk(1'b1, 2'd2, 1'b0, 32'h44, 32'h3333_4444, 32'h0, 1'b0), "w3_sw44");

    // req held high: one access every five cycles, inputs scribbled while busy
    @(negedge clk);
    we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h40; din = 32'h0; req3 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("thru_ack_k%0d", k), {31'd0, ack3}, {31'd0, (k % 5) == 4});
      check($sformatf("thru_busy_k%0d", k), {31'd0, busy3}, {31'd0, (k % 5) != 0});
      if (ack3) check($sformatf("thru_dout_k%0d", k), dout3, 32'h1111_2222);
      if ((k % 5) >= 1 && (k % 5) <= 3) begin
        we = 1'b1; addr = 32'h44; din = 32'hDEAD_BEEF; size = 2'd0;
      end else if ((k % 5) == 4) begin
        we = 1'b0; addr = 32'h40; din = 32'h0; size = 2'd2;
      end
      if (k == 20) req3 = 1'b0;
    end
    do_access(1'b1, mk(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 32'h3333_4444, 1'b0), "w3_lw44");

    // reset during WAIT of a store
    @(negedge clk);
    we = 1'b1; size = 2'd2; addr = 32'h40; din = 32'h9999_9999; req3 = 1'b1;
    @(negedge clk);
    req3 = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_dout", dout3, 32'd0);
    check("rst_mid_ack", {31'd0, ack3}, 32'd0);
    check("rst_mid_busy", {31'd0, busy3}, 32'd0);
    check("rst_mid_err", {31'd0, err3}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack3) seen++;
    end
    check("rst_mid_no_ack", 32'(seen), 32'd0);
    do_access(1'b1, mk(1'b0, 2'd2, 1'b0, 32'h40,   32'h0, 32'h1111_2222, 1'b0), "rst_word_kept");
    do_access(1'b1, mk(1'b0, 2'd2, 1'b0, 32'h1040, 32'h0, 32'h1111_2222, 1'b0), "alias_lw1040");
    do_access(1'b0, mk(1'b1, 2'd2, 1'b0, 32'h1000, 32'h5A5A_5A5A, 32'h0, 1'b0), "alias_sw1000");
    do_access(1'b0, mk(1'b0, 2'd2, 1'b0, 32'h0,    32'h0, 32'h5A5A_5A5A, 1'b0), "alias_lw0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
